// File: rtl/acs_sequencer_pkg.sv
// Shared constants and state encoding for the Viterbi ACS control sequencer.
package acs_sequencer_pkg;

    localparam int ACS_WD_FSM      = 6;
    localparam int ACS_N_SEG       = 1 << ACS_WD_FSM;
    localparam int ACS_STARTUP     = 8;
    localparam int ACS_TB_INTERVAL = 16;
    localparam int ACS_WD_CNT      = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_WAIT_TB = 2'd2
    } acs_state_e;

endpackage

// File: rtl/acs_symbol_counter.sv
// Per-symbol bookkeeping: saturating start-up count gating CompareStart,
// and a wrapping traceback interval count flagging the symbol that is due.
module acs_symbol_counter
    import acs_sequencer_pkg::*;
#(
    parameter int STARTUP     = ACS_STARTUP,
    parameter int TB_INTERVAL = ACS_TB_INTERVAL,
    parameter int WD_CNT      = ACS_WD_CNT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic step_i,
    output logic compare_start_o,
    output logic tb_due_o
);

    localparam logic [WD_CNT-1:0] STARTUP_C = WD_CNT'(STARTUP);
    localparam logic [WD_CNT-1:0] TB_LAST   = WD_CNT'(TB_INTERVAL - 1);

    logic [WD_CNT-1:0] startup_q, startup_d;
    logic [WD_CNT-1:0] tb_q, tb_d;

    assign compare_start_o = (startup_q >= STARTUP_C);
    assign tb_due_o        = (tb_q == TB_LAST);

    always_comb begin
        startup_d = startup_q;
        tb_d      = tb_q;
        if (clear_i) begin
            startup_d = '0;
            tb_d      = '0;
        end else if (step_i) begin
            if (startup_q < STARTUP_C) begin
                startup_d = startup_q + 1'b1;
            end
            tb_d = tb_due_o ? '0 : tb_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            startup_q <= '0;
            tb_q      <= '0;
        end else begin
            startup_q <= startup_d;
            tb_q      <= tb_d;
        end
    end

endmodule

// File: rtl/acs_sequencer.sv
// ACS control sequencer: sweeps all trellis segments per accepted symbol and
// schedules traceback starts, stalling symbol intake while traceback is busy.
module acs_sequencer
    import acs_sequencer_pkg::*;
#(
    parameter int WD_FSM      = ACS_WD_FSM,
    parameter int STARTUP     = ACS_STARTUP,
    parameter int TB_INTERVAL = ACS_TB_INTERVAL,
    parameter int WD_CNT      = ACS_WD_CNT
) (
    input  logic              Clock_i,
    input  logic              Reset_i,
    input  logic              SymValid_i,
    output logic              SymReady_o,
    input  logic              Flush_i,
    input  logic              TBBusy_i,
    output logic              Active_o,
    output logic              Init_o,
    output logic              Hold_o,
    output logic              CompareStart_o,
    output logic [WD_FSM-1:0] ACSSegment_o,
    output logic              SymbolDone_o,
    output logic              TBStart_o
);

    localparam int                N_SEG    = 1 << WD_FSM;
    localparam logic [WD_FSM-1:0] SEG_LAST = WD_FSM'(N_SEG - 1);

    acs_state_e        state_q, state_d;
    logic [WD_FSM-1:0] seg_q, seg_d;
    logic              active_q, active_d;
    logic              init_q, init_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              tbstart_q, tbstart_d;
    logic              cnt_clear, cnt_step;
    logic              startup_done, tb_due;
    logic              last_seg, sym_ready;

    assign last_seg = (seg_q == SEG_LAST);

    always_comb begin
        state_d   = state_q;
        seg_d     = seg_q;
        done_d    = 1'b0;
        tbstart_d = 1'b0;
        sym_ready = 1'b0;
        cnt_clear = 1'b0;
        cnt_step  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                sym_ready = 1'b1;
                cnt_clear = Flush_i;
                seg_d     = '0;
                if (SymValid_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_seg) begin
                    sym_ready = !(tb_due && TBBusy_i);
                    cnt_step  = 1'b1;
                    done_d    = 1'b1;
                    seg_d     = '0;
                    tbstart_d = tb_due && !TBBusy_i;
                    if (tb_due && TBBusy_i) begin
                        state_d = ST_WAIT_TB;
                    end else if (SymValid_i) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    seg_d = seg_q + 1'b1;
                end
            end
            ST_WAIT_TB: begin
                seg_d = '0;
                if (!TBBusy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                seg_d   = '0;
            end
        endcase
        active_d = (state_d == ST_RUN);
        init_d   = active_d && (seg_d == '0);
        hold_d   = active_d && (seg_d == SEG_LAST);
    end

    always_ff @(posedge Clock_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q   <= ST_IDLE;
            seg_q     <= '0;
            active_q  <= 1'b0;
            init_q    <= 1'b0;
            hold_q    <= 1'b0;
            done_q    <= 1'b0;
            tbstart_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            seg_q     <= seg_d;
            active_q  <= active_d;
            init_q    <= init_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            tbstart_q <= tbstart_d;
        end
    end

    acs_symbol_counter #(
        .STARTUP     (STARTUP),
        .TB_INTERVAL (TB_INTERVAL),
        .WD_CNT      (WD_CNT)
    ) u_symbol_counter (
        .clk_i           (Clock_i),
        .rst_i           (Reset_i),
        .clear_i         (cnt_clear),
        .step_i          (cnt_step),
        .compare_start_o (startup_done),
        .tb_due_o        (tb_due)
    );

    // Counter only moves at a sweep boundary, so this is steady across a sweep.
    assign CompareStart_o = active_q && startup_done;
    assign SymReady_o     = sym_ready;
    assign Active_o       = active_q;
    assign Init_o         = init_q;
    assign Hold_o         = hold_q;
    assign ACSSegment_o   = seg_q;
    assign SymbolDone_o   = done_q;
    // A deferred traceback fires in the very cycle the traceback unit frees up.
    assign TBStart_o      = tbstart_q || ((state_q == ST_WAIT_TB) && !TBBusy_i);

endmodule

// File: tb/tb_acs_sequencer.sv
// Directed bench for acs_sequencer with 4 segments/symbol, STARTUP=8, TB_INTERVAL=4.
module tb_acs_sequencer;

    localparam int WD_FSM = 2;

    logic              Clock_i = 1'b0;
    logic              Reset_i;
    logic              SymValid_i;
    logic              Flush_i;
    logic              TBBusy_i;
    logic              SymReady_o;
    logic              Active_o;
    logic              Init_o;
    logic              Hold_o;
    logic              CompareStart_o;
    logic [WD_FSM-1:0] ACSSegment_o;
    logic              SymbolDone_o;
    logic              TBStart_o;

    acs_sequencer #(
        .WD_FSM      (WD_FSM),
        .STARTUP     (8),
        .TB_INTERVAL (4),
        .WD_CNT      (8)
    ) dut (
        .Clock_i        (Clock_i),
        .Reset_i        (Reset_i),
        .SymValid_i     (SymValid_i),
        .SymReady_o     (SymReady_o),
        .Flush_i        (Flush_i),
        .TBBusy_i       (TBBusy_i),
        .Active_o       (Active_o),
        .Init_o         (Init_o),
        .Hold_o         (Hold_o),
        .CompareStart_o (CompareStart_o),
        .ACSSegment_o   (ACSSegment_o),
        .SymbolDone_o   (SymbolDone_o),
        .TBStart_o      (TBStart_o)
    );

    always #5 Clock_i = ~Clock_i;

    // One row = one clock cycle: inputs driven during it, outputs seen in it.
    typedef struct {
        string      name;
        logic       sv;
        logic       fl;
        logic       bz;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic logic [9:0] pk(logic act, logic init, logic hold, logic cmp,
                                      logic [1:0] seg, logic done, logic tbs, logic rdy);
        return {act, init, hold, cmp, seg, done, tbs, rdy};
    endfunction

    task automatic check(input string name, input logic [9:0] exp);
        logic [9:0] got;
        got = {Active_o, Init_o, Hold_o, CompareStart_o, ACSSegment_o,
               SymbolDone_o, TBStart_o, SymReady_o};
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: act,init,hold,cmp,seg[2],done,tbstart,ready got %b expected %b",
                     name, got, exp);
        end
    endtask

    task automatic add(input string n, input logic sv, input logic fl, input logic bz,
                       input logic [9:0] e);
        vec_t v;
        v.name = n;
        v.sv   = sv;
        v.fl   = fl;
        v.bz   = bz;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic add_idle(input string n, input logic sv, input logic fl,
                            input logic done, input logic tbs);
        add(n, sv, fl, 1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, done, tbs, 1'b1));
    endtask

    task automatic add_sym(input string n, input logic cmp, input logic done_first,
                           input logic sv, input logic fl, input logic sv_last,
                           input logic bz_last, input logic rdy_last);
        for (int s = 0; s < 4; s++) begin
            add($sformatf("%s.seg%0d", n, s),
                (s == 3) ? sv_last : sv, fl, (s == 3) ? bz_last : 1'b0,
                pk(1'b1, s == 0, s == 3, cmp, 2'(s), (s == 0) ? done_first : 1'b0,
                   1'b0, (s == 3) ? rdy_last : 1'b0));
        end
    endtask

    task automatic run_vecs();
        foreach (vecs[i]) begin
            @(posedge Clock_i);
            #1;
            SymValid_i = vecs[i].sv;
            Flush_i    = vecs[i].fl;
            TBBusy_i   = vecs[i].bz;
            #1;
            check(vecs[i].name, vecs[i].exp);
        end
        vecs.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        Reset_i    = 1'b1;
        SymValid_i = 1'b0;
        Flush_i    = 1'b0;
        TBBusy_i   = 1'b0;
        repeat (2) @(posedge Clock_i);
        #1;
        check("reset", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1));
        Reset_i = 1'b0;

        // Single symbol from reset, then idle.
        add_idle("a.idle", 1, 0, 0, 0);
        add_sym ("a.s1", 0, 0, 0, 0, 0, 0, 1);
        add_idle("a.done", 0, 0, 1, 0);
        // Symbols 2-4 back to back; symbol 4 is traceback-due with TB free.
        add_idle("b.idle", 1, 0, 0, 0);
        add_sym ("b.s2", 0, 0, 1, 0, 1, 0, 1);
        add_sym ("b.s3", 0, 1, 1, 0, 1, 0, 1);
        add_sym ("b.s4", 0, 1, 1, 0, 0, 0, 1);
        add_idle("b.done", 0, 0, 1, 1);
        // Symbols 5-8; TBStart again with symbol 8.
        add_idle("c.idle", 1, 0, 0, 0);
        add_sym ("c.s5", 0, 0, 1, 0, 1, 0, 1);
        add_sym ("c.s6", 0, 1, 1, 0, 1, 0, 1);
        add_sym ("c.s7", 0, 1, 1, 0, 1, 0, 1);
        add_sym ("c.s8", 0, 1, 1, 0, 0, 0, 1);
        add_idle("c.done", 0, 0, 1, 1);
        // Symbols 9-10 compare; Flush during symbol 9's sweep has no effect.
        add_idle("d.idle", 1, 0, 0, 0);
        add_sym ("d.s9", 1, 0, 1, 1, 1, 0, 1);
        add_sym ("d.s10", 1, 1, 1, 0, 0, 0, 1);
        add_idle("d.done", 0, 0, 1, 0);
        // Flush in IDLE with SymValid restarts the start-up window.
        add_idle("e.flush", 1, 1, 0, 0);
        add_sym ("e.s11", 0, 0, 0, 0, 0, 0, 1);
        add_idle("e.done", 0, 0, 1, 0);
        run_vecs();

        // Reset asserted asynchronously at segment 2.
        add_idle("r.idle", 1, 0, 0, 0);
        add_sym ("r.sx", 0, 0, 0, 0, 0, 0, 1);
        void'(vecs.pop_back());
        run_vecs();
        #1;
        Reset_i    = 1'b1;
        SymValid_i = 1'b0;
        #1;
        check("r.async", pk(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1));
        @(posedge Clock_i);
        #1;
        Reset_i = 1'b0;

        // Fresh counters: symbol 4 is due while TB is busy for 5 cycles.
        add_idle("t.idle", 1, 0, 0, 0);
        add_sym ("t.s1", 0, 0, 1, 0, 1, 0, 1);
        add_sym ("t.s2", 0, 1, 1, 0, 1, 0, 1);
        add_sym ("t.s3", 0, 1, 1, 0, 1, 0, 1);
        add_sym ("t.s4", 0, 1, 0, 0, 1, 1, 0);
        add("t.w1", 1, 0, 1, pk(0, 0, 0, 0, 2'd0, 1, 0, 0));
        add("t.w2", 1, 0, 1, pk(0, 0, 0, 0, 2'd0, 0, 0, 0));
        add("t.w3", 1, 0, 1, pk(0, 0, 0, 0, 2'd0, 0, 0, 0));
        add("t.w4", 1, 0, 1, pk(0, 0, 0, 0, 2'd0, 0, 0, 0));
        add("t.w5", 1, 0, 0, pk(0, 0, 0, 0, 2'd0, 0, 1, 0));
        add_idle("t.accept", 1, 0, 0, 0);
        add_sym ("t.s5", 0, 0, 0, 0, 0, 0, 1);
        add_idle("t.done", 0, 0, 1, 0);
        run_vecs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
